// File: rtl/iter_mult.sv
// Iterative shift-add multiplier for MULT/MULTU: one partial-product step per cycle,
// sign fix-up in a dedicated cycle, fixed 34-cycle latency from accept to done pulse.
module iter_mult #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mul_valid,
   input  logic             mul_signed,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             mul_busy,
   output logic             mul_done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   timer_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [WIDTH:0]     accHi_q;
   logic               neg_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   resultHi_q;
   logic [WIDTH-1:0]   resultLo_q;

   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     stepSum;
   logic [WIDTH:0]     accHi_d;
   logic [WIDTH-1:0]   mplier_d;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] result_d;

   // Magnitudes of signed operands; the most negative value maps onto itself and is
   // then treated as an unsigned magnitude, which is exactly what the datapath needs.
   always_comb begin
      magA     = (mul_signed && src_a[WIDTH-1]) ? -src_a : src_a;
      magB     = (mul_signed && src_b[WIDTH-1]) ? -src_b : src_b;
      stepSum  = accHi_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      {accHi_d, mplier_d} = {stepSum, mplier_q} >> 1;
      product  = {accHi_q[WIDTH-1:0], mplier_q};
      result_d = neg_q ? -product : product;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         accHi_q    <= '0;
         neg_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         resultHi_q <= '0;
         resultLo_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mul_valid && !cancel) begin
                  mcand_q  <= magA;
                  mplier_q <= magB;
                  neg_q    <= mul_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  accHi_q  <= '0;
                  timer_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               if (cancel) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  accHi_q  <= accHi_d;
                  mplier_q <= mplier_d;
                  timer_q  <= timer_q + CNT_W'(1);
                  if (timer_q == CNT_W'(WIDTH - 1)) begin
                     state_q <= FIX;
                  end
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               if (cancel) begin
                  state_q <= IDLE;
               end else begin
                  resultHi_q <= result_d[2*WIDTH-1:WIDTH];
                  resultLo_q <= result_d[WIDTH-1:0];
                  done_q     <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mul_busy  = busy_q;
   assign mul_done  = done_q;
   assign result_hi = resultHi_q;
   assign result_lo = resultLo_q;

endmodule

// File: tb/tb_iter_mult.sv
// Scoreboard bench for iter_mult: stimulus pushes expected products with their due
// cycle, a negedge monitor pops and compares on every mul_done pulse.
module tb_iter_mult;

   logic        clk = 1'b0;
   logic        reset;
   logic        mulValid;
   logic        mulSigned;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        cancel;
   logic        mulBusy;
   logic        mulDone;
   logic [31:0] resultHi;
   logic [31:0] resultLo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycle;
   } exp_t;

   exp_t sbQ[$];
   exp_t monEntry;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   n0;

   iter_mult dut (
      .clk       (clk),
      .reset     (reset),
      .mul_valid (mulValid),
      .mul_signed(mulSigned),
      .src_a     (srcA),
      .src_b     (srcB),
      .cancel    (cancel),
      .mul_busy  (mulBusy),
      .mul_done  (mulDone),
      .result_hi (resultHi),
      .result_lo (resultLo)
   );

   // Free-running clock and a cycle counter that the due-cycle bookkeeping keys on.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives a start request for the current cycle; optionally records the expected result.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                input logic [63:0] prod, input bit expectIt);
      mulValid  = 1'b1;
      mulSigned = sgn;
      srcA      = a;
      srcB      = b;
      if (expectIt) sbQ.push_back('{prod[63:32], prod[31:0], cyc + 34});
   endtask

   task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] prod);
      applyStimulus(a, b, sgn, prod, 1'b1);
      step(1);
      mulValid = 1'b0;
      step(36);
   endtask

   // Every done pulse must match the oldest pending expectation in value and timing.
   always @(negedge clk) begin
      if (!reset && mulDone) begin
         if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected done: got pulse with hi=%h lo=%h expected none (cycle %0d)",
                     resultHi, resultLo, cyc);
         end else begin
            monEntry = sbQ.pop_front();
            checkOutput("done cycle", 64'(cyc), 64'(monEntry.cycle));
            checkOutput("result_hi", {32'h0, resultHi}, {32'h0, monEntry.hi});
            checkOutput("result_lo", {32'h0, resultLo}, {32'h0, monEntry.lo});
         end
      end
   end

   initial begin
      reset     = 1'b1;
      mulValid  = 1'b0;
      mulSigned = 1'b0;
      srcA      = '0;
      srcB      = '0;
      cancel    = 1'b0;
      step(3);
      @(negedge clk);
      checkOutput("reset busy", {63'h0, mulBusy}, 64'h0);
      checkOutput("reset done", {63'h0, mulDone}, 64'h0);
      checkOutput("reset hi", {32'h0, resultHi}, 64'h0);
      checkOutput("reset lo", {32'h0, resultLo}, 64'h0);
      step(1);
      reset = 1'b0;
      step(2);

      // MULTU max x max with a cycle-accurate busy window.
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1'b1);
      for (int k = 0; k <= 34; k++) begin
         @(negedge clk);
         checkOutput($sformatf("busy@N+%0d", k), {63'h0, mulBusy}, {63'h0, (k >= 1 && k <= 33)});
         if (k == 0) begin
            @(posedge clk);
            #1;
            mulValid = 1'b0;
         end
      end
      step(3);

      runOp(32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
      runOp(32'h00000007, 32'hFFFFFFFD, 1'b0, 64'h00000006_FFFFFFEB);
      runOp(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
      runOp(32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFF_FFFFFFFF);

      // Cancel mid-calculation, then restart in the first cycle busy is low.
      runOp(32'd3, 32'd5, 1'b0, 64'd15);
      applyStimulus(32'h1234, 32'h10, 1'b0, 64'h0, 1'b0);
      step(1);
      mulValid = 1'b0;
      step(9);
      cancel = 1'b1;
      step(1);
      cancel = 1'b0;
      @(negedge clk);
      checkOutput("cancel busy", {63'h0, mulBusy}, 64'h0);
      checkOutput("cancel done", {63'h0, mulDone}, 64'h0);
      checkOutput("cancel hi held", {32'h0, resultHi}, 64'h0);
      checkOutput("cancel lo held", {32'h0, resultLo}, 64'd15);
      applyStimulus(32'h1234, 32'h10, 1'b0, 64'h12340, 1'b1);
      step(1);
      mulValid = 1'b0;
      step(36);

      // Start requests during CALC and DONE must be ignored.
      applyStimulus(32'd3, 32'd4, 1'b0, 64'd12, 1'b1);
      step(1);
      mulValid = 1'b0;
      step(4);
      applyStimulus(32'hAAAA, 32'h5555, 1'b0, 64'h0, 1'b0);
      step(1);
      mulValid = 1'b0;
      step(28);
      applyStimulus(32'd9, 32'd9, 1'b0, 64'h0, 1'b0);
      step(1);
      applyStimulus(32'h10000, 32'h10000, 1'b0, 64'h00000001_00000000, 1'b1);
      step(1);
      mulValid = 1'b0;
      step(36);

      // Reset in the middle of an operation clears everything.
      applyStimulus(32'hFFFFFFFF, 32'h2, 1'b0, 64'h0, 1'b0);
      step(1);
      mulValid = 1'b0;
      step(19);
      reset = 1'b1;
      step(1);
      @(negedge clk);
      checkOutput("midreset busy", {63'h0, mulBusy}, 64'h0);
      checkOutput("midreset done", {63'h0, mulDone}, 64'h0);
      checkOutput("midreset hi", {32'h0, resultHi}, 64'h0);
      checkOutput("midreset lo", {32'h0, resultLo}, 64'h0);
      step(1);
      reset = 1'b0;
      step(1);
      runOp(32'h0, 32'hDEADBEEF, 1'b0, 64'h0);

      @(negedge clk);
      checkOutput("pending results", 64'(sbQ.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/iter_mult.md
Name: iter_mult

Overview:
- Iterative shift-add multiplier for MULT/MULTU in the execute stage; the multiplication counterpart of the restoring-division unit.
- Takes two 32-bit operands and a signed/unsigned flag.
- Produces a 64-bit product as HI/LO after a fixed 34-cycle latency.
- Supports flush by exception or branch cancel.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is required to work.
- CNT_W, 6, width of the iteration timer; must hold the value WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- mul_valid  input  1  start request; operands sampled when accepted
- mul_signed  input  1  1 = MULT (two's complement), 0 = MULTU
- src_a  input  32  multiplicand
- src_b  input  32  multiplier
- cancel  input  1  flush; aborts any in-flight operation
- mul_busy  output  1  operation in progress; a new start is not accepted
- mul_done  output  1  one-cycle pulse; result_hi/result_lo valid
- result_hi  output  32  product [63:32]
- result_lo  output  32  product [31:0]

Behaviour:
- Reset: state IDLE, timer 0, mul_busy 0, mul_done 0, result_hi 0, result_lo 0, all internal registers 0. Reset overrides every other input.
- States and transitions:
  - IDLE -> CALC when mul_valid & !cancel.
  - CALC -> FIX when timer == 31.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
  - Any state except IDLE -> IDLE when cancel.
- Accept (cycle N, IDLE, mul_valid=1, cancel=0):
  - Latch mcand = |src_a| and mplier = |src_b|. Magnitude is taken only when mul_signed=1 and the operand's bit 31 = 1.
  - 0x80000000 has magnitude 0x80000000, treated as unsigned.
  - Latch neg = mul_signed & (src_a[31] ^ src_b[31]).
  - Clear acc_hi (33-bit) to 0 and timer to 0.
- CALC, cycles N+1..N+32, timer 0..31:
  - sum = acc_hi + (mplier[0] ? {1'b0,mcand} : 0).
  - {acc_hi, mplier} <= {sum, mplier} >> 1 (65-bit logical shift right).
  - timer increments.
- After 32 steps, {acc_hi[31:0], mplier} holds the unsigned 64-bit product; acc_hi[32] = 0.
- FIX, cycle N+33:
  - result = neg ? (~prod + 1) : prod, computed at 64 bits.
  - Written into result_hi/result_lo at the end of this cycle.
- DONE, cycle N+34: mul_done=1 for exactly this cycle, with result_hi/result_lo valid.
- Results hold their value until the next FIX write or reset. They are not cleared by cancel or by the return to IDLE.
- mul_busy = 1 in CALC and FIX; 0 in IDLE and DONE.
- Start requests are accepted only in IDLE. mul_valid in CALC, FIX or DONE is ignored; operands are not re-sampled.
- Cancel rules:
  - Cancel in CALC or FIX: next state IDLE, mul_done stays 0, results unchanged, busy drops the next cycle.
  - Cancel in DONE: mul_done still pulses that cycle.
  - cancel with mul_valid in IDLE: cancel wins, no accept.
- Operands are not required to stay stable after the accept cycle.
- Zero operands take no early exit; latency is always 34 cycles from accept to the done pulse.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, accept at N -> mul_done only at N+34; result_hi=0xFFFFFFFE, result_lo=0x00000001; mul_busy high N+1..N+33.
- MULT 7 × 0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU on the same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0xFFFFFFFF × 0x00000001 -> hi=lo=0xFFFFFFFF.
- Complete 3×5 (lo=15), then start 0x1234×0x10 and assert cancel at N+10 -> no mul_done; mul_busy 0 from N+11; result stays hi=0, lo=15; a restart at N+11 is accepted and yields lo=0x12340.
- mul_valid pulsed with different operands at N+5 and at N+34 (DONE) -> ignored; only the first product is reported, and the next accept happens no earlier than N+35.
- reset asserted at N+20 -> next cycle all outputs 0 and state IDLE; then MULTU 0 × 0xDEADBEEF -> hi=lo=0 at N'+34.
